// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle processor control unit: state encoding,
// opcode constants, ALU operation codes and datapath mux select codes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
`ifdef MULTICYCLE_CONTROL_JAL_EN
        S_JAL       = 4'd9,
`endif
        S_HALT      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Also consumed by the ALU control decoder.
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_BRIMM = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: decode_next = S_MEM_ADDR;
            OP_RTYPE:          decode_next = S_EXECUTE;
            OP_BRANCH:         decode_next = S_BRANCH;
`ifdef MULTICYCLE_CONTROL_JAL_EN
            OP_JAL:            decode_next = S_JAL;
`endif
            default:           decode_next = S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RISC-V style datapath (ir_write/pc_write in
// FETCH follow mem_ready). Optional JAL support via MULTICYCLE_CONTROL_JAL_EN.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal
);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PC_SRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = M2R_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_ADD;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                // Gated by rst_n so nothing is latched while reset holds the FSM here.
                ir_write  = mem_ready & rst_n;
                pc_write  = mem_ready & rst_n;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_BRIMM;
                state_d   = decode_next(opcode);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                state_d       = S_FETCH;
            end
`ifdef MULTICYCLE_CONTROL_JAL_EN
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC;
                state_d    = S_FETCH;
            end
`endif
            S_HALT: begin
                illegal = 1'b1;
            end
            default: state_d = S_HALT;
        endcase
    end

endmodule
